// File: rtl/fc_pkg.sv
// Shared constants and state encoding for the FC layer input path.
package fc_pkg;

    localparam int FC_LANES   = 9;
    localparam int FC_BEATS   = 16;
    localparam int FC_IN_NUM  = FC_LANES * FC_BEATS;
    localparam int FC_OUT_NUM = 10;
    localparam int FC_DATA_W  = 12;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } fc_state_t;

endpackage

// File: rtl/fc_input_serializer_if.sv
// Upstream word port and downstream 9-lane beat port of the FC input serializer.
interface fc_input_serializer_if #(
    parameter int DATA_W = fc_pkg::FC_DATA_W
);
    import fc_pkg::*;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
    // in_valid/in_data are offered by the pooling stage and taken when in_ready=1;
    // valid_out/data_out_*/out_last are offered to the FC layer, held stable until out_ready=1.
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_ready;
    logic [DATA_W-1:0] data_out_1;
    logic [DATA_W-1:0] data_out_2;
    logic [DATA_W-1:0] data_out_3;
    logic [DATA_W-1:0] data_out_4;
    logic [DATA_W-1:0] data_out_5;
    logic [DATA_W-1:0] data_out_6;
    logic [DATA_W-1:0] data_out_7;
    logic [DATA_W-1:0] data_out_8;
    logic [DATA_W-1:0] data_out_9;
    logic              valid_out;
    logic              out_last;
    logic              frame_done;
    fc_state_t         state;

    // master is the serializer itself; slave is the surrounding pipeline.
    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, data_out_1, data_out_2, data_out_3, data_out_4, data_out_5,
               data_out_6, data_out_7, data_out_8, data_out_9,
               valid_out, out_last, frame_done, state
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, data_out_1, data_out_2, data_out_3, data_out_4, data_out_5,
               data_out_6, data_out_7, data_out_8, data_out_9,
               valid_out, out_last, frame_done, state
    );

endinterface

// File: rtl/fc_feature_buf.sv
// Feature frame storage: single write port, combinational 9-lane read addressed by beat.
module fc_feature_buf
    import fc_pkg::*;
#(
    parameter int LANES  = FC_LANES,
    parameter int BEATS  = FC_BEATS,
    parameter int DATA_W = FC_DATA_W,
    parameter int DEPTH  = LANES * BEATS,
    parameter int AW     = $clog2(DEPTH),
    parameter int BW     = $clog2(BEATS)
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [BW-1:0]                rd_beat,
    output logic [LANES-1:0][DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents survive reset; a frame is always fully rewritten before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign rd_data[l] = mem[AW'(l * BEATS) + AW'(rd_beat)];
    end

endmodule

// File: rtl/fc_input_serializer.sv
// Collects a channel-major 144-word feature frame and replays it as 16 beats x 9 lanes,
// followed by zero-data drain beats that step the FC layer through its output neurons.
module fc_input_serializer
    import fc_pkg::*;
#(
    parameter int LANES   = FC_LANES,
    parameter int BEATS   = FC_BEATS,
    parameter int DATA_W  = FC_DATA_W,
    parameter int N_DRAIN = FC_OUT_NUM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fc_input_serializer_if.master bus
);

    localparam int DEPTH  = LANES * BEATS;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int CNT_W  = (N_DRAIN > 0) ? $clog2(N_DRAIN + 1) : 1;
    localparam logic [7:0]        LAST_WR    = 8'(DEPTH - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = (N_DRAIN > 0) ? CNT_W'(N_DRAIN - 1) : '0;

    fc_state_t                   state_q, state_next;
    logic [7:0]                  wr_idx;
    logic [BEAT_W-1:0]           beat, beat_nxt, rd_beat;
    logic [CNT_W-1:0]            drain_cnt;
    logic [LANES-1:0][DATA_W-1:0] rd_data, data_q;
    logic                        valid_q, last_q, done_q;
    logic                        in_ready_c, wr_en;
    logic                        fill_last, send_fire, send_last, drain_fire, drain_last;

    fc_feature_buf #(
        .LANES (LANES),
        .BEATS (BEATS),
        .DATA_W(DATA_W)
    ) u_buf (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_idx),
        .wr_data(bus.in_data),
        .rd_beat(rd_beat),
        .rd_data(rd_data)
    );

    assign beat_nxt   = beat + BEAT_W'(1);
    assign fill_last  = wr_en && (wr_idx == LAST_WR);
    assign send_fire  = (state_q == SEND) && valid_q && bus.out_ready;
    assign send_last  = send_fire && (beat == LAST_BEAT);
    assign drain_fire = (state_q == DRAIN) && valid_q && bus.out_ready;
    assign drain_last = drain_fire && (drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_next;
    end

    always_comb begin : next_state
        state_next = state_q;
        unique case (state_q)
            FILL:    if (fill_last)  state_next = SEND;
            SEND:    if (send_last)  state_next = (N_DRAIN > 0) ? DRAIN : FILL;
            DRAIN:   if (drain_last) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // While sending, the buffer is already looking at the following beat so it can be
    // registered on the accepting edge; at the end of a fill it looks at beat 0.
    always_comb begin : output_decode
        in_ready_c = 1'b0;
        wr_en      = 1'b0;
        rd_beat    = '0;
        unique case (state_q)
            FILL: begin
                in_ready_c = 1'b1;
                wr_en      = bus.in_valid;
            end
            SEND:    rd_beat = beat_nxt;
            DRAIN:   rd_beat = '0;
            default: rd_beat = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : datapath
        if (!rst_n) begin
            wr_idx    <= '0;
            beat      <= '0;
            drain_cnt <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wr_en) wr_idx <= fill_last ? 8'd0 : wr_idx + 8'd1;
            if (fill_last) begin
                valid_q <= 1'b1;
                data_q  <= rd_data;
                last_q  <= (LAST_BEAT == '0);
                beat    <= '0;
            end
            if (send_fire) begin
                if (send_last) begin
                    beat   <= '0;
                    data_q <= '0;
                    last_q <= 1'b0;
                    if (N_DRAIN == 0) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end else begin
                    beat   <= beat_nxt;
                    data_q <= rd_data;
                    last_q <= (beat_nxt == LAST_BEAT);
                end
            end
            if (drain_fire) begin
                if (drain_last) begin
                    drain_cnt <= '0;
                    valid_q   <= 1'b0;
                    done_q    <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.valid_out  = valid_q;
    assign bus.out_last   = last_q;
    assign bus.frame_done = done_q;
    assign bus.state      = state_q;
    assign bus.data_out_1 = data_q[0];
    assign bus.data_out_2 = data_q[1];
    assign bus.data_out_3 = data_q[2];
    assign bus.data_out_4 = data_q[3];
    assign bus.data_out_5 = data_q[4];
    assign bus.data_out_6 = data_q[5];
    assign bus.data_out_7 = data_q[6];
    assign bus.data_out_8 = data_q[7];
    assign bus.data_out_9 = data_q[8];

endmodule

// File: tb/tb_fc_input_serializer.sv
// Directed bench for fc_input_serializer: ramp, drain, backpressure, sign, illegal input, reset.
module tb_fc_input_serializer;
  import fc_pkg::*;

  localparam int W  = FC_DATA_W;
  localparam int EW = FC_LANES * W + 2;  // {valid, last, lane9..lane1}
  localparam int FRAME_BEATS = FC_BEATS + FC_OUT_NUM;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_input_serializer_if #(.DATA_W(W)) bus ();

  fc_input_serializer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail = 0;
  logic [W-1:0] frame [FC_IN_NUM];
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] observed();
    return {bus.valid_out, bus.out_last, bus.data_out_9, bus.data_out_8, bus.data_out_7,
            bus.data_out_6, bus.data_out_5, bus.data_out_4, bus.data_out_3, bus.data_out_2,
            bus.data_out_1};
  endfunction

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // scoreboard model: beat b, lane k carries frame[k*BEATS + b]; then zero drain beats
  task automatic load_expected();
    logic [EW-1:0] v;
    for (int b = 0; b < FC_BEATS; b++) begin
      v = '0;
      v[EW-1] = 1'b1;
      v[EW-2] = (b == FC_BEATS - 1);
      for (int k = 0; k < FC_LANES; k++) v[k*W +: W] = frame[k*FC_BEATS + b];
      exp_q.push_back(v);
    end
    for (int d = 0; d < FC_OUT_NUM; d++) begin
      v = '0;
      v[EW-1] = 1'b1;
      exp_q.push_back(v);
    end
  endtask

  // driver: one word per cycle, optional idle cycle every 'gap' words
  task automatic push_frame(input int gap);
    for (int i = 0; i < FC_IN_NUM; i++) begin
      if (gap > 0 && (i % gap) == gap - 1) begin
        bus.in_valid = 1'b0;
        bus.in_data = 12'h555;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data = frame[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // receiver: accept max_beats beats; stall two cycles on beat stall_beat; optional junk input
  task automatic run_out(input int stall_beat, input int max_beats, input bit junk);
    int cyc = 0;
    int got = 0;
    int stall = 0;
    int held = 0;
    int fd = 0;
    while (got < max_beats && cyc < 1000) begin
      cyc++;
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.in_data = 12'hAAA;
        check("in_ready_low", bus.in_ready, 1'b0);
      end
      bus.out_ready = !(got == stall_beat && stall < 2);
      if (got == stall_beat) held++;
      if (bus.frame_done) fd++;
      if (bus.out_ready) begin
        check($sformatf("beat%0d", got), observed(), exp_q.pop_front());
        got++;
      end else begin
        stall++;
        check("stall_hold", observed(), (exp_q.size() > 0) ? exp_q[0] : '0);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("out_budget", got, max_beats);
    check("early_frame_done", fd, 0);
    if (stall_beat >= 0) check("stall_cycles", held, 3);
  endtask

  task automatic end_frame();
    check("frame_done_pulse", bus.frame_done, 1'b1);
    check("in_ready_at_done", bus.in_ready, 1'b1);
    check("valid_after_drain", bus.valid_out, 1'b0);
    check("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check("frame_done_one_cycle", bus.frame_done, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_valid", bus.valid_out, 1'b0);
    check("rst_last", bus.out_last, 1'b0);
    check("rst_done", bus.frame_done, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_data", observed(), '0);
    check("rst_state", bus.state, FILL);
    rst_n = 1'b1;
    @(negedge clk);

    // ramp and drain
    for (int i = 0; i < FC_IN_NUM; i++) frame[i] = W'(i);
    push_frame(0);
    check("ramp_b0_valid", bus.valid_out, 1'b1);
    check("ramp_b0_lane1", bus.data_out_1, 12'd0);
    check("ramp_b0_lane2", bus.data_out_2, 12'd16);
    check("ramp_b0_lane9", bus.data_out_9, 12'd128);
    check("ramp_b0_last", bus.out_last, 1'b0);
    check("ramp_b0_state", bus.state, SEND);
    load_expected();
    run_out(-1, FC_BEATS - 1, 1'b0);
    check("ramp_b15_lane1", bus.data_out_1, 12'd15);
    check("ramp_b15_lane9", bus.data_out_9, 12'd143);
    check("ramp_b15_last", bus.out_last, 1'b1);
    run_out(-1, FRAME_BEATS - (FC_BEATS - 1), 1'b0);
    end_frame();

    // backpressure on beat 3
    for (int i = 0; i < FC_IN_NUM; i++) frame[i] = W'(i * 3 + 7);
    push_frame(0);
    load_expected();
    run_out(3, FRAME_BEATS, 1'b0);
    end_frame();

    // sign pass-through
    for (int i = 0; i < FC_IN_NUM; i++) frame[i] = W'($urandom_range(0, 4095));
    frame[0] = 12'hF80;
    frame[FC_IN_NUM-1] = 12'h7FF;
    push_frame(0);
    check("sign_lane1_b0", bus.data_out_1, 12'hF80);
    load_expected();
    run_out(-1, FC_BEATS - 1, 1'b0);
    check("sign_lane9_b15", bus.data_out_9, 12'h7FF);
    run_out(-1, FRAME_BEATS - (FC_BEATS - 1), 1'b0);
    end_frame();

    // illegal input during SEND/DRAIN, then a gapped ramp must come out intact
    for (int i = 0; i < FC_IN_NUM; i++) frame[i] = W'(i + 2000);
    push_frame(0);
    load_expected();
    run_out(-1, FRAME_BEATS, 1'b1);
    end_frame();
    for (int i = 0; i < FC_IN_NUM; i++) frame[i] = W'(i);
    push_frame(5);
    check("recheck_b0_lane9", bus.data_out_9, 12'd128);
    load_expected();
    run_out(-1, FRAME_BEATS, 1'b0);
    end_frame();

    // reset at beat 7 of SEND
    for (int i = 0; i < FC_IN_NUM; i++) frame[i] = W'(i * 5 + 1);
    push_frame(0);
    load_expected();
    run_out(-1, 7, 1'b0);
    check("pre_reset_beat7", observed(), exp_q[0]);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.valid_out, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_data", observed(), '0);
    check("midrst_state", bus.state, FILL);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    for (int i = 0; i < FC_IN_NUM; i++) frame[i] = W'(4095 - i);
    push_frame(0);
    check("post_rst_b0_lane1", bus.data_out_1, 12'd4095);
    check("post_rst_b0_lane9", bus.data_out_9, 12'd3967);
    load_expected();
    run_out(-1, FRAME_BEATS, 1'b0);
    end_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
